// File: rtl/pu_riscv_dmem_arbiter.sv
// Two-port round-robin arbiter sharing the core's data-memory port between the LSU (port 0)
// and a secondary master (port 1), with a watchdog that error-completes a hung access.
module pu_riscv_dmem_arbiter #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req0,
  input  logic [XLEN-1:0] adr0,
  input  logic [XLEN-1:0] d0,
  input  logic            we0,
  input  logic [2:0]      size0,
  output logic            ack0,
  output logic [XLEN-1:0] q0,
  output logic            err0,
  input  logic            req1,
  input  logic [XLEN-1:0] adr1,
  input  logic [XLEN-1:0] d1,
  input  logic            we1,
  input  logic [2:0]      size1,
  output logic            ack1,
  output logic [XLEN-1:0] q1,
  output logic            err1,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_adr,
  output logic [XLEN-1:0] mem_d,
  output logic            mem_we,
  output logic [2:0]      mem_size,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_q,
  input  logic            mem_err,
  output logic [1:0]      gnt,
  output logic            busy,
  output logic            timeout_flag
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic            ptr;      // 0: port 0 favoured on a tie, 1: port 1 favoured
  logic [CW-1:0]   cnt;
  logic            ack_hit;
  logic            tmo_hit;
  logic            done;
  logic            pick;

  always_comb begin
    ack_hit = (state == BUSY) && mem_ack;
    // a real ack in the same cycle as expiry takes precedence
    tmo_hit = (TIMEOUT != 0) && (state == BUSY) && !mem_ack && (cnt == CW'(TIMEOUT));
    done    = ack_hit || tmo_hit;
    pick    = (req0 && req1) ? ptr : req1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      gnt          <= '0;
      mem_req      <= 1'b0;
      busy         <= 1'b0;
      timeout_flag <= 1'b0;
      ptr          <= 1'b0;
      cnt          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            state   <= BUSY;
            gnt     <= pick ? 2'b10 : 2'b01;
            mem_req <= 1'b1;
            busy    <= 1'b1;
            cnt     <= CW'(1);
          end
        end
        BUSY: begin
          if (done) begin
            state   <= IDLE;
            gnt     <= '0;
            mem_req <= 1'b0;
            busy    <= 1'b0;
            cnt     <= '0;
            ptr     <= gnt[0];
            if (tmo_hit) timeout_flag <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_adr  = gnt[1] ? adr1  : adr0;
    mem_d    = gnt[1] ? d1    : d0;
    mem_we   = gnt[1] ? we1   : we0;
    mem_size = gnt[1] ? size1 : size0;

    ack0 = gnt[0] && done;
    ack1 = gnt[1] && done;
    err0 = gnt[0] && (ack_hit ? mem_err : tmo_hit);
    err1 = gnt[1] && (ack_hit ? mem_err : tmo_hit);
    q0   = (gnt[0] && ack_hit) ? mem_q : '0;
    q1   = (gnt[1] && ack_hit) ? mem_q : '0;
  end

endmodule

// File: tb/tb_pu_riscv_dmem_arbiter.sv
// Randomized transaction-level bench for pu_riscv_dmem_arbiter; expected grant order and
// completion timing come from a request-set / latency model of the arbitration rules.
module tb_pu_riscv_dmem_arbiter;

  localparam int XLEN = 64;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            rstn;
  logic [1:0]      req_v;
  logic [XLEN-1:0] adr_v [2];
  logic [XLEN-1:0] d_v   [2];
  logic            we_v  [2];
  logic [2:0]      size_v[2];
  logic            ack0, ack1, err0, err1;
  logic [XLEN-1:0] q0, q1;
  logic            mem_req, mem_we, mem_ack, mem_err;
  logic [XLEN-1:0] mem_adr, mem_d, mem_q;
  logic [2:0]      mem_size;
  logic [1:0]      gnt;
  logic            busy, timeout_flag;

  int n_vec = 0;
  int n_err = 0;

  // reference model state: outstanding requests, tie-break favourite, sticky flag
  logic [1:0] pending;
  int         favour;
  logic       exp_tflag;

  always #5 clk = ~clk;

  pu_riscv_dmem_arbiter #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req_v[0]), .adr0(adr_v[0]), .d0(d_v[0]), .we0(we_v[0]), .size0(size_v[0]),
    .ack0(ack0), .q0(q0), .err0(err0),
    .req1(req_v[1]), .adr1(adr_v[1]), .d1(d_v[1]), .we1(we_v[1]), .size1(size_v[1]),
    .ack1(ack1), .q1(q1), .err1(err1),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_d(mem_d), .mem_we(mem_we), .mem_size(mem_size),
    .mem_ack(mem_ack), .mem_q(mem_q), .mem_err(mem_err),
    .gnt(gnt), .busy(busy), .timeout_flag(timeout_flag)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic rand_payload(input int p);
    adr_v[p]  = {$urandom, $urandom};
    d_v[p]    = {$urandom, $urandom};
    we_v[p]   = 1'($urandom);
    size_v[p] = 3'($urandom);
  endtask

  task automatic do_reset();
    rstn = 1'b0; req_v = '0; mem_ack = 1'b0; mem_err = 1'b0; mem_q = '0;
    pending = '0; favour = 0; exp_tflag = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Entered at posedge+1 in IDLE. delay = BUSY cycle carrying mem_ack (0 or > TO: never).
  task automatic do_txn(input logic [1:0] newreq, input int delay, input logic err,
                        input logic [63:0] rdata);
    logic [1:0] want;
    logic [1:0] oh;
    int w, o, k;
    bit done, ack_c, tmo_c;
    want  = newreq | pending;
    req_v = want;
    mem_ack = 1'b0;
    w  = (want == 2'b11) ? favour : (want[1] ? 1 : 0);
    o  = 1 - w;
    oh = (w == 0) ? 2'b01 : 2'b10;
    @(negedge clk);
    check("idle_gnt", 64'(gnt), 64'd0);
    check("idle_mreq", 64'(mem_req), 64'd0);
    @(posedge clk); #1;
    done = 0;
    k = 1;
    while (!done) begin
      ack_c = (k == delay) && (delay <= TO);
      tmo_c = !ack_c && (k == TO);
      mem_ack = ack_c; mem_q = rdata; mem_err = err;
      @(negedge clk);
      check("gnt", 64'(gnt), 64'(oh));
      check("busy", 64'(busy), 64'd1);
      check("mem_req", 64'(mem_req), 64'd1);
      check("mem_adr", mem_adr, adr_v[w]);
      check("mem_d", mem_d, d_v[w]);
      check("mem_we", 64'(mem_we), 64'(we_v[w]));
      check("mem_size", 64'(mem_size), 64'(size_v[w]));
      check("tflag", 64'(timeout_flag), 64'(exp_tflag));
      check("ack_g", 64'(w == 0 ? ack0 : ack1), 64'(ack_c | tmo_c));
      check("err_g", 64'(w == 0 ? err0 : err1), 64'(ack_c ? err : tmo_c));
      check("q_g", (w == 0) ? q0 : q1, ack_c ? rdata : 64'd0);
      check("ack_o", 64'(o == 0 ? ack0 : ack1), 64'd0);
      check("err_o", 64'(o == 0 ? err0 : err1), 64'd0);
      check("q_o", (o == 0) ? q0 : q1, 64'd0);
      if (tmo_c) exp_tflag = 1'b1;
      done = ack_c | tmo_c;
      @(posedge clk); #1;
      k++;
      if (done) begin
        mem_ack  = 1'b0;
        req_v[w] = 1'b0;
        pending  = want & ~oh;
        favour   = o;
      end
    end
  endtask

  initial begin
    for (int p = 0; p < 2; p++) begin
      adr_v[p] = '0; d_v[p] = '0; we_v[p] = 1'b0; size_v[p] = '0;
    end
    do_reset();
    @(negedge clk);
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_mreq", 64'(mem_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tflag", 64'(timeout_flag), 64'd0);
    check("rst_ack", 64'({ack1, ack0, err1, err0}), 64'd0);
    check("rst_q", q0 | q1, 64'd0);
    @(posedge clk); #1;

    // single LSU read, ack on 3rd BUSY cycle
    adr_v[0] = 64'h1000; we_v[0] = 1'b0; size_v[0] = 3'b011;
    do_txn(2'b01, 3, 1'b0, 64'hDEADBEEF);

    // both ports continuously requesting: port0 first, then alternation
    do_reset();
    rand_payload(0); rand_payload(1);
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++) if (!pending[p]) rand_payload(p);
      do_txn(2'b11, 1, 1'b0, {$urandom, $urandom});
    end
    do_txn(2'b00, 1, 1'b0, {$urandom, $urandom});

    // watchdog expiry on port 1, then a stray ack in IDLE
    do_reset();
    rand_payload(1);
    do_txn(2'b10, 0, 1'b0, {$urandom, $urandom});
    mem_ack = 1'b1; mem_q = 64'h1234;
    @(negedge clk);
    check("stray_ack", 64'({ack1, ack0}), 64'd0);
    check("stray_mreq", 64'(mem_req), 64'd0);
    check("stray_tflag", 64'(timeout_flag), 64'd1);
    @(posedge clk); #1 mem_ack = 1'b0;
    @(negedge clk);
    check("stray_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;

    // ack coinciding with expiry is a normal completion
    do_reset();
    rand_payload(0);
    do_txn(2'b01, TO, 1'b0, 64'hCAFE);
    @(negedge clk);
    check("coinc_tflag", 64'(timeout_flag), 64'd0);
    @(posedge clk); #1;

    // port 1 write completing with a memory error
    adr_v[1] = 64'h2000; d_v[1] = 64'h5A5A; we_v[1] = 1'b1; size_v[1] = 3'b010;
    do_txn(2'b10, 3, 1'b1, 64'h0);

    // reset pulse while BUSY on port 0
    rand_payload(0);
    req_v = 2'b01;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    #1 rstn = 1'b0;
    #1;
    check("arst_mreq", 64'(mem_req), 64'd0);
    check("arst_gnt", 64'(gnt), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_ack", 64'(ack0), 64'd0);
    @(posedge clk); #1 req_v = '0;
    check("arst_ack2", 64'(ack0), 64'd0);
    @(negedge clk) rstn = 1'b1;
    pending = '0; favour = 0; exp_tflag = 1'b0;
    @(posedge clk); #1;
    rand_payload(0);
    do_txn(2'b01, 2, 1'b0, {$urandom, $urandom});

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      logic [1:0] nr;
      nr = 2'($urandom_range(1, 3));
      for (int p = 0; p < 2; p++) if (nr[p] && !pending[p]) rand_payload(p);
      do_txn(nr, $urandom_range(1, 6), 1'($urandom), {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pu_riscv_dmem_arbiter.md
Name: pu_riscv_dmem_arbiter

Overview:
Two-requester arbiter that shares the core's single data-memory port between the load-store unit (port 0) and a secondary master such as the page-table walker or debug unit (port 1).
- Grants one requester at a time and holds the grant until the memory acknowledges.
- Routes the acknowledge, read data and error back to the granted requester only.
- Uses a round-robin policy and a watchdog timeout so that a hung memory cannot stall the pipeline forever.
- Sits between the LSU dmem_* interface and the bus interface unit.

Parameters:
XLEN, 64, data and address width.
TIMEOUT, 255, maximum number of BUSY cycles to wait for mem_ack before error completion; 0 disables the watchdog.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
req0/req1  in  1  request from port 0 (LSU) / port 1 (secondary)
adr0/adr1  in  XLEN  request address
d0/d1  in  XLEN  write data
we0/we1  in  1  write enable
size0/size1  in  3  access size code (passed through unmodified)
ack0/ack1  out  1  completion pulse to the requester
q0/q1  out  XLEN  read data to the requester
err0/err1  out  1  error flag, valid with ack
mem_req  out  1  request to memory
mem_adr  out  XLEN  address to memory
mem_d  out  XLEN  write data to memory
mem_we  out  1  write enable to memory
mem_size  out  3  size to memory
mem_ack  in  1  memory completion pulse
mem_q  in  XLEN  memory read data
mem_err  in  1  memory error, valid with mem_ack
gnt  out  2  one-hot current grant (00 when idle)
busy  out  1  high in BUSY state
timeout_flag  out  1  sticky flag, set on any watchdog expiry, cleared only by reset

Behaviour:
- Requester protocol: the requester holds reqN and its payload stable from assertion until the cycle it sees ackN. The requester may drop or re-present a request in the cycle after ackN.
- Reset (asynchronous, rstn=0):
  - state=IDLE, gnt=00, mem_req=0, busy=0, timeout_flag=0.
  - Round-robin pointer set to port 0 favoured; watchdog counter=0.
  - All ackN/errN are 0; qN are 0.
  - Reset asserted mid-transaction abandons the transaction; no ack is issued to either port.
- State IDLE:
  - If only one reqN is high, grant that port.
  - If both are high, grant the port favoured by the pointer.
  - The grant is registered: a request sampled in cycle N produces gnt and mem_req=1 in cycle N+1, and state moves to BUSY.
  - A mem_ack arriving in IDLE (a stray/late ack) is ignored, with no requester ack.
- State BUSY:
  - mem_req=1; mem_adr/mem_d/mem_we/mem_size are muxed combinationally from the granted port.
  - The watchdog counter increments each cycle, starting from 1 in the first BUSY cycle.
  - When mem_ack=1: ackN=1 for the granted port in the same cycle (combinational), qN=mem_q, errN=mem_err. On the next edge: state=IDLE, gnt=00, mem_req=0, counter=0, and the pointer moves to favour the other port.
  - When TIMEOUT!=0, the counter equals TIMEOUT and mem_ack=0: ackN=1 and errN=1 for the granted port, qN=0, and timeout_flag is set. On the next edge: state=IDLE, mem_req drops, the pointer toggles.
  - If mem_ack and the timeout coincide, mem_ack wins; this is a normal completion and the flag is not set.
  - Loss of the granted reqN while BUSY is a protocol violation; the arbiter stays BUSY until mem_ack or timeout.
- Ungranted port: ackN=0, errN=0, qN=0 at all times.
- Throughput: at least one IDLE cycle between consecutive transactions. Best-case cycle from request to next grant is 1 cycle after the ack.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1.
- No payload is registered; all payload paths are pure muxes on the registered gnt.

Test Plan:
1. Reset, then req0 with adr0=0x1000, we0=0, mem_ack after 3 cycles with mem_q=0xDEADBEEF → mem_req rises 1 cycle after req0; ack0=1 and q0=0xDEADBEEF in the mem_ack cycle; ack1 stays 0; gnt returns to 00.
2. req0 and req1 asserted together out of reset, memory acks each after 1 cycle → grant order is port0 then port1; grants alternate for 4 transactions; gnt is never 11.
3. TIMEOUT=4, req1 granted, mem_ack held at 0 → on the 4th BUSY cycle ack1=1, err1=1, q1=0; timeout_flag=1; mem_req=0 on the next cycle. A later stray mem_ack produces no ack0/ack1.
4. mem_ack and the timeout in the same cycle (ack on BUSY cycle 4, TIMEOUT=4), mem_err=0 → ack0=1, err0=0, timeout_flag stays 0.
5. rstn pulsed low for 1 cycle while BUSY on port0 → mem_req, gnt and busy go to 0 immediately (asynchronously); no ack0 is issued; a new req0 afterwards is granted normally.
6. Write from port1 (we1=1, d1=0x5A5A, size1=3'b010) → mem_we=1, mem_d=0x5A5A, mem_size=3'b010 throughout BUSY; a mem_err=1 on the ack cycle yields err1=1.
